// File: rtl/spu_pkg.sv
// spu_pkg: shared sizes, types and execution-unit latencies for the SPU issue scoreboard
package spu_pkg;
  localparam int NUM_REGS = 128;
  localparam int CNT_W = 3;
  localparam int MAX_LAT = 7;
  localparam int STALL_CNT_W = 16;
  localparam int NUM_UNITS = 8;
  typedef logic [6:0] reg_addr_t;
  typedef logic [2:0] lat_t;
  typedef enum logic [2:0] {SF1, SF2, BYTE, PERM, LS, SP, SPINT, BR} unit_e;
  function automatic lat_t lat_of(unit_e u);
    return u == SF1 ? 3'd2 : (u == LS || u == SP) ? 3'd6 : u == SPINT ? 3'd7 : u == BR ? 3'd1 : 3'd4;
  endfunction
endpackage

// File: rtl/spu_issue_scoreboard_if.sv
// spu_issue_scoreboard_if: decode request, dispatch and stall-counter bundle of the issue scoreboard
interface spu_issue_scoreboard_if;
  import spu_pkg::*;
  logic in_valid;
  logic in_ready;
  unit_e in_unit;
  logic in_nop;
  reg_addr_t in_ra_addr;
  reg_addr_t in_rb_addr;
  reg_addr_t in_rc_addr;
  reg_addr_t in_rt_addr;
  logic in_use_ra;
  logic in_use_rb;
  logic in_use_rc;
  logic in_reg_write;
  logic [NUM_UNITS-1:0] issue_valid;
  reg_addr_t issue_rt_addr;
  logic issue_reg_write;
  logic [STALL_CNT_W-1:0] stall_cycles;
  modport master (
    output in_valid, in_unit, in_nop, in_ra_addr, in_rb_addr, in_rc_addr, in_rt_addr,
           in_use_ra, in_use_rb, in_use_rc, in_reg_write,
    input  in_ready, issue_valid, issue_rt_addr, issue_reg_write, stall_cycles
  );
  modport slave (
    input  in_valid, in_unit, in_nop, in_ra_addr, in_rb_addr, in_rc_addr, in_rt_addr,
           in_use_ra, in_use_rb, in_use_rc, in_reg_write,
    output in_ready, issue_valid, issue_rt_addr, issue_reg_write, stall_cycles
  );
endinterface

// File: rtl/spu_wb_reservation.sv
// spu_wb_reservation: shift-register tracker of future cycles that already own the single writeback port
module spu_wb_reservation
  import spu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  lat_t chk_slot,
  output logic chk_busy,
  input  logic rsv_en,
  input  lat_t rsv_slot
);
  logic [MAX_LAT-1:0] res_q, res_d;
  assign chk_busy = res_q[chk_slot];
  always_comb res_d = (res_q | (rsv_en ? MAX_LAT'(1) << rsv_slot : '0)) >> 1;
  always_ff @(posedge clk) begin
    if (reset) res_q <= '0;
    else res_q <= res_d;
  end
endmodule

// File: rtl/spu_issue_scoreboard.sv
// spu_issue_scoreboard: in-order single-issue RAW/WAW/writeback-port hazard scoreboard ahead of the SPU units
module spu_issue_scoreboard
  import spu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  spu_issue_scoreboard_if.slave bus
);
  logic [CNT_W-1:0] pend_q [NUM_REGS];
  logic [CNT_W-1:0] pend_d [NUM_REGS];
  logic [NUM_UNITS-1:0] issue_valid_q, issue_valid_d;
  reg_addr_t issue_rt_addr_q, issue_rt_addr_d;
  logic issue_reg_write_q, issue_reg_write_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  lat_t slot;
  logic raw, waw, wb_busy, accept, load;
  assign slot = lat_of(bus.in_unit) - 3'd1;
  assign raw = (bus.in_use_ra && pend_q[bus.in_ra_addr] != '0) ||
               (bus.in_use_rb && pend_q[bus.in_rb_addr] != '0) ||
               (bus.in_use_rc && pend_q[bus.in_rc_addr] != '0);
  assign waw = bus.in_reg_write && pend_q[bus.in_rt_addr] > slot;
  assign bus.in_ready = bus.in_nop || !(raw || waw || (bus.in_reg_write && wb_busy));
  assign accept = bus.in_valid && bus.in_ready && !bus.in_nop;
  assign load = accept && bus.in_reg_write;
  spu_wb_reservation u_wb (
    .clk      (clk),
    .reset    (reset),
    .chk_slot (slot),
    .chk_busy (wb_busy),
    .rsv_en   (load),
    .rsv_slot (slot)
  );
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      pend_d[i] = (load && bus.in_rt_addr == reg_addr_t'(i)) ? slot : pend_q[i] - CNT_W'(pend_q[i] != '0);
    issue_valid_d = accept ? NUM_UNITS'(1) << bus.in_unit : '0;
    issue_rt_addr_d = accept ? bus.in_rt_addr : issue_rt_addr_q;
    issue_reg_write_d = accept ? bus.in_reg_write : issue_reg_write_q;
    stall_cycles_d = stall_cycles_q + STALL_CNT_W'(bus.in_valid && !bus.in_ready && stall_cycles_q != '1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '{default: '0};
      issue_valid_q <= '0;
      issue_rt_addr_q <= '0;
      issue_reg_write_q <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      pend_q <= pend_d;
      issue_valid_q <= issue_valid_d;
      issue_rt_addr_q <= issue_rt_addr_d;
      issue_reg_write_q <= issue_reg_write_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_rt_addr = issue_rt_addr_q;
  assign bus.issue_reg_write = issue_reg_write_q;
  assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// tb_spu_issue_scoreboard: directed and random checks of the issue scoreboard against a cycle-number model
module tb_spu_issue_scoreboard;
  import spu_pkg::*;
  typedef struct packed {
    bit v;
    bit [2:0] u;
    bit nop;
    bit [6:0] ra;
    bit [6:0] rb;
    bit [6:0] rc;
    bit [6:0] rt;
    bit ua;
    bit ub;
    bit uc;
    bit wr;
  } req_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wb_edge [128];
  bit taken [int];
  logic [7:0] e_iv = '0;
  logic [6:0] e_rt = '0;
  logic e_wr = 1'b0;
  int e_stall = 0;
  int lat_tab [8] = '{2, 4, 4, 4, 6, 6, 7, 1};
  spu_issue_scoreboard_if bus();
  spu_issue_scoreboard dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", n, a, e, cyc);
    end
  endtask
  function automatic req_t mk(int u, int rt, bit wr, int ra, bit ua);
    req_t r = '0;
    r.v = 1'b1;
    r.u = 3'(u);
    r.rt = 7'(rt);
    r.wr = wr;
    r.ra = 7'(ra);
    r.ua = ua;
    return r;
  endfunction
  // result of a write accepted at edge c lands at edge c+LAT; readers may go at that edge, later writers must land after it
  function automatic bit m_ready(req_t r);
    int c = cyc;
    int l = lat_tab[r.u];
    bit raw, waw, wbc;
    if (r.nop) return 1'b1;
    raw = (r.ua && wb_edge[r.ra] > c) || (r.ub && wb_edge[r.rb] > c) || (r.uc && wb_edge[r.rc] > c);
    waw = r.wr && (c + l <= wb_edge[r.rt]);
    wbc = r.wr && taken.exists(c + l);
    return !(raw || waw || wbc);
  endfunction
  task automatic apply(req_t r);
    bus.in_valid = r.v;
    bus.in_unit = unit_e'(r.u);
    bus.in_nop = r.nop;
    bus.in_ra_addr = r.ra;
    bus.in_rb_addr = r.rb;
    bus.in_rc_addr = r.rc;
    bus.in_rt_addr = r.rt;
    bus.in_use_ra = r.ua;
    bus.in_use_rb = r.ub;
    bus.in_use_rc = r.uc;
    bus.in_reg_write = r.wr;
  endtask
  task automatic drive(input req_t r, output bit rdy);
    bit mr;
    apply(r);
    #1;
    mr = m_ready(r);
    rdy = bus.in_ready;
    chk("in_ready", 32'(bus.in_ready), 32'(mr));
    @(posedge clk);
    if (reset) begin
      foreach (wb_edge[i]) wb_edge[i] = 0;
      taken.delete();
      e_iv = '0;
      e_rt = '0;
      e_wr = 1'b0;
      e_stall = 0;
    end else begin
      if (r.v && !mr && e_stall < 65535) e_stall++;
      if (r.v && mr && !r.nop) begin
        e_iv = 8'(1) << r.u;
        e_rt = r.rt;
        e_wr = r.wr;
        if (r.wr) begin
          wb_edge[r.rt] = cyc + lat_tab[r.u];
          taken[cyc + lat_tab[r.u]] = 1'b1;
        end
      end else e_iv = '0;
    end
    if (taken.exists(cyc)) taken.delete(cyc);
    cyc++;
    @(negedge clk);
    chk("issue_valid", 32'(bus.issue_valid), 32'(e_iv));
    chk("issue_rt_addr", 32'(bus.issue_rt_addr), 32'(e_rt));
    chk("issue_reg_write", 32'(bus.issue_reg_write), 32'(e_wr));
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(e_stall));
  endtask
  task automatic send(input req_t r, output int waits);
    bit rdy;
    waits = 0;
    drive(r, rdy);
    while (!rdy && waits < 20) begin
      waits++;
      drive(r, rdy);
    end
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept after %0d cycles, expected accept", waits);
    end
  endtask
  task automatic idle(int n);
    bit rdy;
    repeat (n) drive('0, rdy);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish by 500000");
    $fatal(1, "timeout");
  end
  initial begin
    req_t r;
    int w;
    bit rdy;
    apply('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_issue_rt", 32'(bus.issue_rt_addr), 32'd0);
    chk("rst_issue_wr", 32'(bus.issue_reg_write), 32'd0);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    send(mk(SF2, 5, 1, 0, 0), w);
    chk("raw_first_waits", 32'(w), 32'd0);
    send(mk(SF1, 6, 1, 5, 1), w);
    chk("raw_waits", 32'(w), 32'd3);
    chk("raw_stall_cycles", 32'(bus.stall_cycles), 32'd3);
    chk("raw_issue_valid", 32'(bus.issue_valid), 32'h01);
    chk("raw_issue_rt", 32'(bus.issue_rt_addr), 32'd6);
    idle(10);
    send(mk(SF2, 1, 1, 0, 0), w);
    idle(1);
    send(mk(SF1, 2, 1, 0, 0), w);
    chk("wb_conflict_waits", 32'(w), 32'd1);
    idle(10);
    send(mk(SPINT, 9, 1, 0, 0), w);
    send(mk(SF1, 9, 1, 0, 0), w);
    chk("waw_waits", 32'(w), 32'd5);
    idle(10);
    for (int i = 1; i <= 3; i++) begin
      send(mk(SF1, i, 1, 0, 0), w);
      chk("stream_waits", 32'(w), 32'd0);
      chk("stream_issue_valid", 32'(bus.issue_valid), 32'h01);
      chk("stream_issue_rt", 32'(bus.issue_rt_addr), 32'(i));
    end
    idle(10);
    send(mk(SF2, 5, 1, 0, 0), w);
    r = '0;
    r.v = 1'b1;
    r.nop = 1'b1;
    send(r, w);
    chk("nop_waits", 32'(w), 32'd0);
    chk("nop_no_dispatch", 32'(bus.issue_valid), 32'd0);
    send(mk(BR, 0, 0, 5, 1), w);
    chk("br_raw_waits", 32'(w), 32'd2);
    chk("br_issue_valid", 32'(bus.issue_valid), 32'h80);
    idle(10);
    send(mk(SF2, 5, 1, 0, 0), w);
    r = mk(SF1, 6, 1, 5, 1);
    drive(r, rdy);
    reset = 1'b1;
    drive(r, rdy);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("midrst_issue_rt", 32'(bus.issue_rt_addr), 32'd0);
    chk("midrst_issue_wr", 32'(bus.issue_reg_write), 32'd0);
    chk("midrst_stall", 32'(bus.stall_cycles), 32'd0);
    idle(3);
    for (int n = 0; n < 3000; n++) begin
      r.v = $urandom_range(0, 9) < 7;
      r.u = 3'($urandom_range(0, 7));
      r.nop = $urandom_range(0, 9) == 0;
      r.ra = 7'($urandom_range(0, 7));
      r.rb = 7'($urandom_range(0, 7));
      r.rc = 7'($urandom_range(0, 7));
      r.rt = 7'($urandom_range(0, 7));
      r.ua = 1'($urandom_range(0, 1));
      r.ub = 1'($urandom_range(0, 1));
      r.uc = $urandom_range(0, 3) == 0;
      r.wr = $urandom_range(0, 4) != 0;
      reset = $urandom_range(0, 299) == 0;
      drive(r, rdy);
      reset = 1'b0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
